// File: rtl/hilo_muldiv_if.sv
// ============================================================================
// Module : hilo_muldiv_if
// Brief  : Issue/result bundle between the EXE stage and the HI/LO mul/div unit
// Rev    : 1.0 initial release
// ============================================================================
`default_nettype none

interface hilo_muldiv_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hilo_rd;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, hilo_rd,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hilo_rd,
        output busy, stall, done, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
// ============================================================================
// Module : hilo_muldiv_unit
// Brief  : Iterative 32-cycle MULT/MULTU/DIV/DIVU plus MTHI/MTLO owning HI/LO
// Rev    : 1.0 initial release
// ============================================================================
`default_nettype none

module hilo_muldiv_unit #(
    parameter int ITER = 32
) (
    input  wire logic       clk,
    input  wire logic       clrn,
    hilo_muldiv_if.slave    bus
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  count;
    logic [63:0] work;
    logic [31:0] divisor;
    logic        is_div;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic        done_reg;

    logic        busy;
    logic        accept;
    logic        accept_md;
    logic        last;
    logic        signed_op;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] rem_shift;
    logic [32:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] product;
    logic [31:0] quotient;
    logic [31:0] remainder;

    assign busy      = (state == S_RUN);
    assign accept    = bus.start && !busy;
    assign accept_md = accept && !bus.op[2];
    assign last      = busy && (count == 5'(ITER - 1));

    assign signed_op = !bus.op[0];
    assign a_neg     = signed_op && bus.a[31];
    assign b_neg     = signed_op && bus.b[31];
    assign a_mag     = a_neg ? -bus.a : bus.a;
    assign b_mag     = b_neg ? -bus.b : bus.b;

    // Multiply: {acc, multiplier} shift right, adding the multiplicand on a 1 bit
    assign mul_sum   = {1'b0, work[63:32]} + (work[0] ? {1'b0, divisor} : 33'd0);
    assign mul_next  = {mul_sum, work[31:1]};

    // Divide: {remainder, dividend/quotient} shift left, restoring on borrow
    assign rem_shift = {work[63:32], work[31]};
    assign div_diff  = rem_shift - {1'b0, divisor};
    assign div_next  = div_diff[32] ? {rem_shift[31:0], work[30:0], 1'b0}
                                    : {div_diff[31:0],  work[30:0], 1'b1};

    assign product   = neg_q ? -mul_next : mul_next;
    assign quotient  = div_zero ? 32'hFFFF_FFFF
                                : (neg_q ? -div_next[31:0] : div_next[31:0]);
    assign remainder = neg_r ? -div_next[63:32] : div_next[63:32];

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept_md) state_next = S_RUN;
            S_RUN:   if (last)      state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clrn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (clrn) begin
            count    <= 5'd0;
            work     <= 64'd0;
            divisor  <= 32'd0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi_reg   <= 32'd0;
            lo_reg   <= 32'd0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= last;
            if (accept_md) begin
                count    <= 5'd0;
                work     <= bus.op[1] ? {32'd0, a_mag} : {32'd0, b_mag};
                divisor  <= bus.op[1] ? b_mag : a_mag;
                is_div   <= bus.op[1];
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
                div_zero <= bus.op[1] && (bus.b == 32'd0);
            end else if (accept && bus.op[2:1] == 2'b10) begin
                if (bus.op[0]) lo_reg <= bus.a;
                else           hi_reg <= bus.a;
            end else if (busy) begin
                count <= count + 5'd1;
                work  <= is_div ? div_next : mul_next;
                // HI/LO are only written here so later stages never see partial values
                if (last) begin
                    if (is_div) begin
                        hi_reg <= remainder;
                        lo_reg <= quotient;
                    end else begin
                        {hi_reg, lo_reg} <= product;
                    end
                end
            end
        end
    end

    assign bus.busy  = busy;
    assign bus.stall = busy && (bus.start || bus.hilo_rd);
    assign bus.done  = done_reg;
    assign bus.hi    = hi_reg;
    assign bus.lo    = lo_reg;

endmodule

`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
// ============================================================================
// Module : tb_hilo_muldiv_unit
// Brief  : Directed self-checking bench for hilo_muldiv_unit
// Rev    : 1.0 initial release
// ============================================================================
`default_nettype none

module tb_hilo_muldiv_unit;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_NOP   = 3'b110;

    logic clk;
    logic clrn;
    int   checks;
    int   errors;

    hilo_muldiv_if bus ();

    hilo_muldiv_unit #(.ITER(32)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Issues an op and returns the number of cycles busy stayed high (bounded).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cycles);
        issue(op, a, b);
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        int   cyc;
        logic bad;
        clrn = 1'b1;
        repeat (2) @(negedge clk);
        clrn = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0 ||
            bus.stall !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: hi=%h lo=%h busy=%b stall=%b done=%b, required 0", bus.hi, bus.lo, bus.busy, bus.stall, bus.done);
        end
        issue(OP_MULTU, 32'd5, 32'd3);
        for (cyc = 1; cyc < 10; cyc++) @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        clrn = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_midop: busy=%b hi=%h lo=%h, required 0 0 0", bus.busy, bus.hi, bus.lo);
        end
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.done !== 1'b0 || bus.busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL reset_no_late_update: hi=%h lo=%h, required 0 0", bus.hi, bus.lo);
        end
    endtask

    task automatic test_mult();
        int cycles;
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cycles);
        checks++;
        if (cycles !== 32) begin
            errors++;
            $display("FAIL multu_latency: busy %0d cycles, required 32", cycles);
        end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL multu_done: done=%b, required 1", bus.done);
        end
        checks++;
        if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin
            errors++;
            $display("FAIL multu_result: hi=%h lo=%h, required fffffffe 00000001", bus.hi, bus.lo);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL multu_done_pulse: done=%b, required 0", bus.done);
        end
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, cycles);
        checks++;
        if (cycles !== 32 || bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFF1) begin
            errors++;
            $display("FAIL mult_signed: cycles=%0d hi=%h lo=%h, required 32 ffffffff fffffff1", cycles, bus.hi, bus.lo);
        end
    endtask

    task automatic test_div();
        int cycles;
        run_op(OP_DIVU, 32'd100, 32'd7, cycles);
        checks++;
        if (cycles !== 32 || bus.lo !== 32'h0000_000E || bus.hi !== 32'h0000_0002) begin
            errors++;
            $display("FAIL divu_basic: cycles=%0d hi=%h lo=%h, required 32 00000002 0000000e", cycles, bus.hi, bus.lo);
        end
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, cycles);
        checks++;
        if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div_signed: hi=%h lo=%h, required ffffffff fffffffd", bus.hi, bus.lo);
        end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cycles);
        checks++;
        if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'd0) begin
            errors++;
            $display("FAIL div_overflow: hi=%h lo=%h, required 00000000 80000000", bus.hi, bus.lo);
        end
        run_op(OP_DIVU, 32'h0000_1234, 32'd0, cycles);
        checks++;
        if (cycles !== 32 || bus.hi !== 32'h0000_1234 || bus.lo !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL divu_by_zero: cycles=%0d hi=%h lo=%h, required 32 00001234 ffffffff", cycles, bus.hi, bus.lo);
        end
    endtask

    task automatic test_mthi_mtlo();
        issue(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
        checks++;
        if (bus.hi !== 32'hDEAD_BEEF || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL mthi: hi=%h busy=%b done=%b, required deadbeef 0 0", bus.hi, bus.busy, bus.done);
        end
        issue(OP_MTLO, 32'd1, 32'd0);
        checks++;
        if (bus.lo !== 32'd1 || bus.hi !== 32'hDEAD_BEEF || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mtlo: hi=%h lo=%h busy=%b, required deadbeef 00000001 0", bus.hi, bus.lo, bus.busy);
        end
        issue(OP_NOP, 32'h5555_5555, 32'h6666_6666);
        @(negedge clk);
        checks++;
        if (bus.lo !== 32'd1 || bus.hi !== 32'hDEAD_BEEF || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL nop_op: hi=%h lo=%h busy=%b, required deadbeef 00000001 0", bus.hi, bus.lo, bus.busy);
        end
    endtask

    task automatic test_stall();
        int   cyc;
        int   cycles;
        logic stall_bad;
        logic hold_bad;
        issue(OP_MULT, 32'd6, 32'd7);
        cyc       = 1;
        stall_bad = 1'b0;
        hold_bad  = 1'b0;
        while (bus.busy === 1'b1 && cyc < 100) begin
            if (cyc == 5) bus.hilo_rd = 1'b1;
            if (cyc == 10) begin
                bus.start = 1'b1;
                bus.op    = OP_DIVU;
                bus.a     = 32'd9;
                bus.b     = 32'd2;
            end else begin
                bus.start = 1'b0;
            end
            #1;
            if (cyc >= 5 && bus.stall !== 1'b1) stall_bad = 1'b1;
            if (cyc < 5 && bus.stall !== 1'b0) stall_bad = 1'b1;
            if (bus.hi !== 32'hDEAD_BEEF || bus.lo !== 32'd1) hold_bad = 1'b1;
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        checks++;
        if (stall_bad || cyc !== 33) begin
            errors++;
            $display("FAIL stall_while_busy: stall_bad=%b busy_end_cycle=%0d, required 0 33", stall_bad, cyc);
        end
        checks++;
        if (hold_bad) begin
            errors++;
            $display("FAIL hilo_stable: hi/lo changed during iteration, required deadbeef/00000001 held");
        end
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd42) begin
            errors++;
            $display("FAIL stall_release: stall=%b hi=%h lo=%h, required 0 00000000 0000002a", bus.stall, bus.hi, bus.lo);
        end
        bus.hilo_rd = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start: busy=%b, required 0", bus.busy);
        end
        run_op(OP_DIVU, 32'd9, 32'd2, cycles);
        checks++;
        if (cycles !== 32 || bus.lo !== 32'd4 || bus.hi !== 32'd1) begin
            errors++;
            $display("FAIL divu_represent: cycles=%0d hi=%h lo=%h, required 32 00000001 00000004", cycles, bus.hi, bus.lo);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        clrn        = 1'b1;
        bus.start   = 1'b0;
        bus.op      = OP_NOP;
        bus.a       = 32'd0;
        bus.b       = 32'd0;
        bus.hilo_rd = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
